cdc_req_ack_receiver: RTL
=========================

Name: cdc_req_ack_receiver

Overview:
- Destination-side receiver for a four-phase req/ack transfer.
- Sits directly downstream of the Synchronizer stage:
  - consumes the synchronized request level;
  - captures the parallel payload, which the sender holds stable;
  - presents the payload on a valid/ready interface;
  - drives the acknowledge level back toward the source domain.
- Also filters short request glitches and flags protocol violations.

Parameters:
- WIDTH, 8, payload width in bits.
- STABLE_CYCLES, 2, consecutive high samples of i_req required before capture; legal range 1..15.

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  reset; synchronous, active-high.
- i_req  input  1  synchronized request level (output of Synchronizer).
- i_dat  input  WIDTH  payload; held stable by the sender while req is high.
- o_valid  output  1  payload available.
- i_ready  input  1  consumer accepts the payload.
- o_dat  output  WIDTH  captured payload.
- o_ack  output  1  acknowledge level back to the source.
- o_busy  output  1  high whenever state != IDLE.
- o_err  output  1  sticky protocol-violation flag.
- i_err_clr  input  1  clears o_err.
- o_glitch_cnt  output  8  saturating count of aborted qualifications.

Behaviour:
- Reset (i_rst high at a rising edge):
  - state=IDLE, qualify counter=0, o_valid=0, o_dat=0, o_ack=0, o_err=0, o_glitch_cnt=0.
  - Reset overrides any in-flight transfer; the captured payload is discarded.
- All outputs are registered; none is combinational from inputs.
- FSM states: IDLE, QUALIFY, HOLD, ACK.
- IDLE:
  - i_req=1 with STABLE_CYCLES=1: capture i_dat into o_dat, go to HOLD.
  - i_req=1 with STABLE_CYCLES>1: counter=1, go to QUALIFY.
  - i_req=0: stay.
- QUALIFY:
  - i_req=1: counter++. When the count reaches STABLE_CYCLES on that edge, capture i_dat and go to HOLD.
  - i_req=0: go to IDLE, counter=0, o_glitch_cnt++ (saturates at 255).
- Capture latency: o_valid rises on the edge that samples the STABLE_CYCLES-th consecutive high i_req.
- HOLD:
  - o_valid=1; o_dat is held constant.
  - o_valid&&i_ready: go to ACK; o_valid=0 and o_ack=1 from that edge.
  - i_ready=0 and i_req=0 (request withdrawn before acceptance): o_valid=0, set o_err, go to IDLE; the payload is dropped.
  - i_ready=1 and i_req=0 in the same cycle: the transfer completes and goes to ACK; no error.
- ACK:
  - o_ack=1 until i_req is sampled 0; then o_ack=0 and go to IDLE on that edge.
  - A new request is accepted only after returning to IDLE; a request already high on the IDLE cycle starts qualification normally.
- o_err:
  - Set and i_err_clr in the same cycle: set wins.
  - Otherwise i_err_clr=1 clears it on the next edge.
- o_dat keeps its last captured value outside HOLD. It is only defined for consumers while o_valid=1.
- Throughput: at most one transfer per 4-phase cycle, minimum STABLE_CYCLES+3 clocks per transfer with an immediately responding sender.

Test Plan:
- Basic transfer, defaults. Raise i_req with i_dat=0xA5, i_ready=1.
  - Required: o_valid high exactly 1 cycle, on the 2nd high sample, with o_dat=0xA5.
  - Required: o_ack high from the next edge until i_req is sampled low, then IDLE with o_busy=0.
- Backpressure. Hold i_ready=0 for 5 cycles after o_valid rises.
  - Required: o_valid and o_dat=0x3C stay stable for those 5 cycles, o_ack=0 throughout.
  - Required: on i_ready=1, one handshake occurs, then o_ack=1.
- Glitch filter. Pulse i_req high for 1 cycle with STABLE_CYCLES=2, repeated 300 times.
  - Required: no o_valid and no o_ack.
  - Required: o_glitch_cnt=255 (saturated).
- Protocol violation. Drop i_req during HOLD with i_ready=0.
  - Required: o_valid falls next edge, o_err=1 and stays set.
  - Required: i_err_clr pulse clears it; a simultaneous new violation keeps it at 1.
- Simultaneous ready/drop. In HOLD, drive i_ready=1 and i_req=0 in the same cycle.
  - Required: one accepted transfer, o_ack=1 for exactly 1 cycle, o_err=0.
- Reset mid-operation. Assert i_rst during HOLD and again during ACK.
  - Required: next edge gives o_valid=0, o_ack=0, o_dat=0, o_busy=0, o_glitch_cnt=0.
  - Required: a following clean request completes normally.

Source files
------------

// File: rtl/cdc_req_ack_receiver.sv
`default_nettype none
// ============================================================================
// Module   : cdc_req_ack_receiver
// Brief    : Destination side of a four-phase req/ack link. It filters request
//            glitches, captures the payload and flags requests withdrawn early.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_req_ack_receiver #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_ack,
  output logic             o_busy,
  output logic             o_err,
  input  logic             i_err_clr,
  output logic [7:0]       o_glitch_cnt
);

  localparam logic [3:0] C_STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_HOLD    = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             err_q, err_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             valid_q, valid_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             err_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    glitch_d = glitch_q;
    err_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          if (C_STABLE == 4'd1) begin
            dat_d   = i_dat;
            state_d = S_HOLD;
          end else begin
            cnt_d   = 4'd1;
            state_d = S_QUALIFY;
          end
        end
      end
      S_QUALIFY: begin
        if (i_req) begin
          if (cnt_q + 4'd1 == C_STABLE) begin
            dat_d   = i_dat;
            cnt_d   = 4'd0;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
          if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end
      end
      S_HOLD: begin
        // Acceptance wins over a simultaneous withdrawal: the consumer already took the data.
        if (i_ready) begin
          state_d = S_ACK;
        end else if (!i_req) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (!i_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d   = err_set | (err_q & ~i_err_clr);
    valid_d = (state_d == S_HOLD);
    ack_d   = (state_d == S_ACK);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      dat_q    <= '0;
      err_q    <= 1'b0;
      glitch_q <= 8'd0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      err_q    <= err_d;
      glitch_q <= glitch_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_dat        = dat_q;
  assign o_ack        = ack_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;
  assign o_glitch_cnt = glitch_q;

endmodule
`default_nettype wire
